// File: rtl/ps2_mouse_register_bank_if.sv
// Packet-adapter and host register-bus signals of the PS/2 mouse register bank.
// The master side drives packets and bus requests; the slave side is the register bank.
interface ps2_mouse_register_bank_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  PacketValid;
   logic                  BtLeft;
   logic                  BtRight;
   logic                  BtMiddle;
   logic [8:0]            XIncrement;
   logic [8:0]            YIncrement;
   logic                  ErrorNoAck;
   logic [7:0]            ReadAddress;
   logic                  ReadStrobe;
   logic [DATA_WIDTH-1:0] DataOut;
   logic [7:0]            WriteAddress;
   logic                  WriteData;
   logic [DATA_WIDTH-1:0] DataIn;
   logic                  Irq;
   logic                  ENoReadReg;
   logic                  ENoWriteReg;

   modport master (
      output PacketValid, BtLeft, BtRight, BtMiddle, XIncrement, YIncrement, ErrorNoAck,
      output ReadAddress, ReadStrobe, WriteAddress, WriteData, DataIn,
      input  DataOut, Irq, ENoReadReg, ENoWriteReg
   );

   modport slave (
      input  PacketValid, BtLeft, BtRight, BtMiddle, XIncrement, YIncrement, ErrorNoAck,
      input  ReadAddress, ReadStrobe, WriteAddress, WriteData, DataIn,
      output DataOut, Irq, ENoReadReg, ENoWriteReg
   );
endinterface

// File: rtl/ps2_mouse_register_bank.sv
// PS/2 mouse register bank: saturating scaled X/Y position, sticky status,
// packet event FIFO with pop-on-read, and a registered level interrupt.
module ps2_mouse_register_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8
) (
   input logic                      Clk,
   input logic                      Reset,
   ps2_mouse_register_bank_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 21;

   localparam logic [7:0] ADDR_POS_X   = 8'h00;
   localparam logic [7:0] ADDR_POS_Y   = 8'h01;
   localparam logic [7:0] ADDR_STATUS  = 8'h02;
   localparam logic [7:0] ADDR_SCALE_X = 8'h03;
   localparam logic [7:0] ADDR_SCALE_Y = 8'h04;
   localparam logic [7:0] ADDR_MAX_X   = 8'h05;
   localparam logic [7:0] ADDR_MAX_Y   = 8'h06;
   localparam logic [7:0] ADDR_EVENT   = 8'h07;
   localparam logic [7:0] ADDR_IRQ_EN  = 8'h08;

   logic [DATA_WIDTH-1:0] posX_q, posX_d, posY_q, posY_d;
   logic [DATA_WIDTH-1:0] scaleX_q, scaleX_d, scaleY_q, scaleY_d;
   logic [DATA_WIDTH-1:0] maxX_q, maxX_d, maxY_q, maxY_d;
   logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
   logic [1:0]            irqEn_q, irqEn_d;
   logic [2:0]            buttons_q, buttons_d;
   logic                  xSign_q, xSign_d, ySign_q, ySign_d;
   logic                  noAck_q, noAck_d, overflow_q, overflow_d;
   logic                  irq_q, irq_d;
   logic [EW-1:0]         fifoMem_q [FIFO_DEPTH];
   logic [PW-1:0]         wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [CW-1:0]         count_q, count_d;

   logic                  full, empty, popEvent, pushOk;
   logic                  wrPosX, wrPosY, wrStatus, wrMaxX, wrMaxY;
   logic [DATA_WIDTH-1:0] rdData, statusWord, eventWord;

   // Signed sum is two bits wider than the register so both underflow and overflow are visible.
   function automatic logic [DATA_WIDTH-1:0] accumulate(input logic [DATA_WIDTH-1:0] pos,
                                                        input logic [8:0]            inc,
                                                        input logic [DATA_WIDTH-1:0] limit);
      logic signed [DATA_WIDTH+1:0] sum;
      logic [DATA_WIDTH-1:0]        result;
      sum = $signed({2'b00, pos}) + $signed({{(DATA_WIDTH-7){inc[8]}}, inc});
      if (sum < 0)
         result = '0;
      else if (sum > $signed({2'b00, limit}))
         result = limit;
      else
         result = sum[DATA_WIDTH-1:0];
      return result;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] scaleRead(input logic [DATA_WIDTH-1:0] pos,
                                                       input logic [5:0]            scale);
      return scale[5] ? (pos >> scale[4:0]) : (pos << scale[4:0]);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] scaleWrite(input logic [DATA_WIDTH-1:0] value,
                                                        input logic [5:0]            scale);
      return scale[5] ? (value << scale[4:0]) : (value >> scale[4:0]);
   endfunction

   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign popEvent = bus.ReadStrobe && (bus.ReadAddress == ADDR_EVENT) && !empty;
   assign pushOk   = bus.PacketValid && (!full || popEvent);

   assign wrPosX   = bus.WriteData && (bus.WriteAddress == ADDR_POS_X);
   assign wrPosY   = bus.WriteData && (bus.WriteAddress == ADDR_POS_Y);
   assign wrStatus = bus.WriteData && (bus.WriteAddress == ADDR_STATUS);
   assign wrMaxX   = bus.WriteData && (bus.WriteAddress == ADDR_MAX_X);
   assign wrMaxY   = bus.WriteData && (bus.WriteAddress == ADDR_MAX_Y);

   assign bus.ENoReadReg  = (bus.ReadAddress > ADDR_IRQ_EN);
   assign bus.ENoWriteReg = !((bus.WriteAddress <= ADDR_MAX_Y) || (bus.WriteAddress == ADDR_IRQ_EN));
   assign bus.DataOut     = dataOut_q;
   assign bus.Irq         = irq_q;

   always_comb begin
      statusWord      = '0;
      statusWord[8:0] = {overflow_q, full, empty, noAck_q, ySign_q, xSign_q, buttons_q};
      eventWord       = '0;
      if (!empty) begin
         eventWord[EW-1:0] = fifoMem_q[rdPtr_q];
         eventWord[23]     = 1'b1;
      end
   end

   always_comb begin
      rdData = '0;
      case (bus.ReadAddress)
         ADDR_POS_X:   rdData = scaleRead(posX_q, scaleX_q[5:0]);
         ADDR_POS_Y:   rdData = scaleRead(posY_q, scaleY_q[5:0]);
         ADDR_STATUS:  rdData = statusWord;
         ADDR_SCALE_X: rdData = scaleX_q;
         ADDR_SCALE_Y: rdData = scaleY_q;
         ADDR_MAX_X:   rdData = maxX_q;
         ADDR_MAX_Y:   rdData = maxY_q;
         ADDR_EVENT:   rdData = eventWord;
         ADDR_IRQ_EN:  rdData = {{(DATA_WIDTH-2){1'b0}}, irqEn_q};
         default:      rdData = '0;
      endcase
   end

   // A POS write beats a coincident packet on its axis; a MAX write pulls POS down to the new limit.
   always_comb begin
      scaleX_d = scaleX_q;
      scaleY_d = scaleY_q;
      maxX_d   = maxX_q;
      maxY_d   = maxY_q;
      irqEn_d  = irqEn_q;
      if (bus.WriteData && bus.WriteAddress == ADDR_SCALE_X) scaleX_d = bus.DataIn;
      if (bus.WriteData && bus.WriteAddress == ADDR_SCALE_Y) scaleY_d = bus.DataIn;
      if (wrMaxX) maxX_d = bus.DataIn;
      if (wrMaxY) maxY_d = bus.DataIn;
      if (bus.WriteData && bus.WriteAddress == ADDR_IRQ_EN) irqEn_d = bus.DataIn[1:0];

      posX_d = posX_q;
      if (wrPosX) begin
         posX_d = scaleWrite(bus.DataIn, scaleX_q[5:0]);
      end else begin
         if (bus.PacketValid) posX_d = accumulate(posX_q, bus.XIncrement, maxX_d);
         if (wrMaxX && posX_d > maxX_d) posX_d = maxX_d;
      end

      posY_d = posY_q;
      if (wrPosY) begin
         posY_d = scaleWrite(bus.DataIn, scaleY_q[5:0]);
      end else begin
         if (bus.PacketValid) posY_d = accumulate(posY_q, bus.YIncrement, maxY_d);
         if (wrMaxY && posY_d > maxY_d) posY_d = maxY_d;
      end
   end

   always_comb begin
      buttons_d  = buttons_q;
      xSign_d    = xSign_q;
      ySign_d    = ySign_q;
      if (bus.PacketValid) begin
         buttons_d = {bus.BtMiddle, bus.BtRight, bus.BtLeft};
         xSign_d   = bus.XIncrement[8];
         ySign_d   = bus.YIncrement[8];
      end
      noAck_d    = bus.ErrorNoAck || (noAck_q && !(wrStatus && bus.DataIn[5]));
      overflow_d = (bus.PacketValid && full && !popEvent) ||
                   (overflow_q && !(wrStatus && bus.DataIn[8]));
      wrPtr_d    = wrPtr_q + PW'(pushOk);
      rdPtr_d    = rdPtr_q + PW'(popEvent);
      count_d    = count_q + CW'(pushOk) - CW'(popEvent);
      dataOut_d  = bus.ReadStrobe ? rdData : dataOut_q;
      irq_d      = (irqEn_q[0] && !empty) || (irqEn_q[1] && overflow_q);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         posX_q     <= '0;
         posY_q     <= '0;
         scaleX_q   <= '0;
         scaleY_q   <= '0;
         maxX_q     <= '1;
         maxY_q     <= '1;
         dataOut_q  <= '0;
         irqEn_q    <= '0;
         buttons_q  <= '0;
         xSign_q    <= 1'b0;
         ySign_q    <= 1'b0;
         noAck_q    <= 1'b0;
         overflow_q <= 1'b0;
         irq_q      <= 1'b0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifoMem_q[i] <= '0;
      end else begin
         posX_q     <= posX_d;
         posY_q     <= posY_d;
         scaleX_q   <= scaleX_d;
         scaleY_q   <= scaleY_d;
         maxX_q     <= maxX_d;
         maxY_q     <= maxY_d;
         dataOut_q  <= dataOut_d;
         irqEn_q    <= irqEn_d;
         buttons_q  <= buttons_d;
         xSign_q    <= xSign_d;
         ySign_q    <= ySign_d;
         noAck_q    <= noAck_d;
         overflow_q <= overflow_d;
         irq_q      <= irq_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         if (pushOk)
            fifoMem_q[wrPtr_q] <= {bus.BtMiddle, bus.BtRight, bus.BtLeft, bus.YIncrement, bus.XIncrement};
      end
   end
endmodule
